// File: rtl/oai21_toggle_sequencer.sv
// oai21_toggle_sequencer: walks one OAI21 cell through Gray-coded input
// vectors, checks sampled QN and counts QN toggles and mismatches.
module oai21_toggle_sequencer #(
  parameter int DWELL_CYCLES = 4,
  parameter int REPS         = 16,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             START,
  input  logic             ABORT,
  input  logic             QN_OBS,
  output logic             IN1,
  output logic             IN2,
  output logic             IN3,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [CNT_W-1:0] TOGGLE_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [2:0]       FIRST_ERR_VEC
);

  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int RP_W = $clog2(REPS + 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state, state_n;
  logic [2:0]       vec, vec_n;
  logic [2:0]       step, step_n;
  logic [DW_W-1:0]  dwell, dwell_n;
  logic [RP_W-1:0]  rep, rep_n;
  logic             prev_valid, prev_valid_n;
  logic             prev_qn, prev_qn_n;
  logic             err, err_n;
  logic [CNT_W-1:0] tog_cnt, tog_cnt_n;
  logic [CNT_W-1:0] err_cnt, err_cnt_n;
  logic [2:0]       first_vec, first_vec_n;

  logic       expected;
  logic       sample;
  logic       last;
  logic [2:0] step_inc;
  logic [2:0] gray_next;

  assign expected  = ~((vec[0] | vec[1]) & vec[2]);
  assign sample    = (dwell == DW_LAST);
  assign last      = sample && (step == 3'd7) && (rep == RP_LAST);
  assign step_inc  = step + 3'd1;
  assign gray_next = step_inc ^ (step_inc >> 1);

  // State and result registers; reset returns everything to zero.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state      <= IDLE;
      vec        <= '0;
      step       <= '0;
      dwell      <= '0;
      rep        <= '0;
      prev_valid <= 1'b0;
      prev_qn    <= 1'b0;
      err        <= 1'b0;
      tog_cnt    <= '0;
      err_cnt    <= '0;
      first_vec  <= '0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      step       <= step_n;
      dwell      <= dwell_n;
      rep        <= rep_n;
      prev_valid <= prev_valid_n;
      prev_qn    <= prev_qn_n;
      err        <= err_n;
      tog_cnt    <= tog_cnt_n;
      err_cnt    <= err_cnt_n;
      first_vec  <= first_vec_n;
    end
  end

  // Next-state, vector sequencing, sampling and saturating counters.
  always_comb begin
    state_n      = state;
    vec_n        = vec;
    step_n       = step;
    dwell_n      = dwell;
    rep_n        = rep;
    prev_valid_n = prev_valid;
    prev_qn_n    = prev_qn;
    err_n        = err;
    tog_cnt_n    = tog_cnt;
    err_cnt_n    = err_cnt;
    first_vec_n  = first_vec;
    unique case (state)
      IDLE: begin
        if (START) begin
          state_n      = RUN;
          vec_n        = '0;
          step_n       = '0;
          dwell_n      = '0;
          rep_n        = '0;
          prev_valid_n = 1'b0;
          err_n        = 1'b0;
          tog_cnt_n    = '0;
          err_cnt_n    = '0;
          first_vec_n  = '0;
        end
      end
      RUN: begin
        unique case (1'b1)
          ABORT: begin
            state_n = IDLE;
            vec_n   = '0;
            step_n  = '0;
            dwell_n = '0;
            rep_n   = '0;
          end
          sample: begin
            if (QN_OBS != expected) begin
              err_n = 1'b1;
              if (!err) first_vec_n = vec;
              if (err_cnt != '1) err_cnt_n = err_cnt + 1'b1;
            end
            if (prev_valid && (QN_OBS != prev_qn)
                && (tog_cnt != '1))
              tog_cnt_n = tog_cnt + 1'b1;
            prev_qn_n    = QN_OBS;
            prev_valid_n = 1'b1;
            dwell_n      = '0;
            if (last) begin
              state_n = FIN;
              vec_n   = '0;
              step_n  = '0;
              rep_n   = '0;
            end else begin
              vec_n  = gray_next;
              step_n = step_inc;
              if (step == 3'd7) rep_n = rep + 1'b1;
            end
          end
          default: dwell_n = dwell + 1'b1;
        endcase
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign {IN3, IN2, IN1} = vec;
  assign BUSY            = (state == RUN);
  assign DONE            = (state == FIN);
  assign ERR             = err;
  assign TOGGLE_CNT      = tog_cnt;
  assign ERR_CNT         = err_cnt;
  assign FIRST_ERR_VEC   = first_vec;

endmodule

// File: tb/tb_oai21_toggle_sequencer.sv
// tb_oai21_toggle_sequencer: directed tests with hand-computed results
// for a REPS=2/DWELL=3 instance and a REPS=1/DWELL=1/CNT_W=2 instance.
module tb_oai21_toggle_sequencer;

  logic clk = 1'b0;
  logic rstb;
  logic start_a, abort_a, start_b, abort_b;
  logic in1_a, in2_a, in3_a, busy_a, done_a, err_a;
  logic in1_b, in2_b, in3_b, busy_b, done_b, err_b;
  logic [15:0] tog_a, ecnt_a;
  logic [1:0]  tog_b, ecnt_b;
  logic [2:0]  fev_a, fev_b;
  logic qn_a, qn_b;
  int   mode_a, mode_b;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Cell model: 0 ideal OAI21, 1 stuck-at-1, 2 stuck-at-0.
  assign qn_a = (mode_a == 0) ? ~((in1_a | in2_a) & in3_a)
                              : (mode_a == 1);
  assign qn_b = (mode_b == 0) ? ~((in1_b | in2_b) & in3_b)
                              : (mode_b == 1);

  oai21_toggle_sequencer #(
    .DWELL_CYCLES(3), .REPS(2), .CNT_W(16)
  ) dut_a (
    .CLK(clk), .RSTB(rstb), .START(start_a), .ABORT(abort_a),
    .QN_OBS(qn_a), .IN1(in1_a), .IN2(in2_a), .IN3(in3_a),
    .BUSY(busy_a), .DONE(done_a), .ERR(err_a),
    .TOGGLE_CNT(tog_a), .ERR_CNT(ecnt_a), .FIRST_ERR_VEC(fev_a)
  );

  oai21_toggle_sequencer #(
    .DWELL_CYCLES(1), .REPS(1), .CNT_W(2)
  ) dut_b (
    .CLK(clk), .RSTB(rstb), .START(start_b), .ABORT(abort_b),
    .QN_OBS(qn_b), .IN1(in1_b), .IN2(in2_b), .IN3(in3_b),
    .BUSY(busy_b), .DONE(done_b), .ERR(err_b),
    .TOGGLE_CNT(tog_b), .ERR_CNT(ecnt_b), .FIRST_ERR_VEC(fev_b)
  );

  function automatic logic [2:0] gray(input int i);
    case (i % 8)
      0:       gray = 3'b000;
      1:       gray = 3'b001;
      2:       gray = 3'b011;
      3:       gray = 3'b010;
      4:       gray = 3'b110;
      5:       gray = 3'b111;
      6:       gray = 3'b101;
      default: gray = 3'b100;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  // Observes 56 cycles of dut_a, counting BUSY cycles, DONE pulses
  // and vector deviations from the Gray order held 3 cycles each.
  task automatic run_a(input bit hold, output int blen,
                       output int dcnt, output int dat,
                       output int vbad);
    blen = 0; dcnt = 0; dat = 0; vbad = 0;
    for (int i = 1; i <= 56; i++) begin
      if (busy_a) begin
        if ({in3_a, in2_a, in1_a} !== gray(blen / 3)) vbad++;
        blen++;
      end
      if (done_a) begin
        dcnt++;
        if (dat == 0) dat = i;
      end
      start_a = hold && (busy_a || done_a);
      tick();
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_a = i[0]; start_b = i[0];
      mode_a = i[0] ? 1 : 2; mode_b = i[0] ? 2 : 1;
      tick();
    end
    n_chk++;
    if ({in3_a, in2_a, in1_a, busy_a, done_a, err_a} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl_a: got %b required 000000",
               {in3_a, in2_a, in1_a, busy_a, done_a, err_a});
    end
    n_chk++;
    if ({tog_a, ecnt_a, fev_a} !== 35'b0) begin
      n_fail++;
      $display("FAIL reset_cnt_a: got %h/%h/%b required 0",
               tog_a, ecnt_a, fev_a);
    end
    n_chk++;
    if ({in3_b, in2_b, in1_b, busy_b, done_b, err_b,
         tog_b, ecnt_b, fev_b} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %b required 0",
               {in3_b, in2_b, in1_b, busy_b, done_b, err_b,
                tog_b, ecnt_b, fev_b});
    end
    start_a = 1'b0; start_b = 1'b0;
    mode_a = 0; mode_b = 0;
    rstb = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    int bl, dc, da, vb;
    mode_a = 0;
    pulse_start_a();
    run_a(1'b0, bl, dc, da, vb);
    n_chk++;
    if (bl !== 48) begin
      n_fail++;
      $display("FAIL nom_busy_len: got %0d required 48", bl);
    end
    n_chk++;
    if (vb !== 0) begin
      n_fail++;
      $display("FAIL nom_vectors: got %0d bad required 0", vb);
    end
    n_chk++;
    if (dc !== 1 || da !== 49) begin
      n_fail++;
      $display("FAIL nom_done: got %0d pulses at %0d required 1 at 49",
               dc, da);
    end
    n_chk++;
    if (tog_a !== 16'd4 || ecnt_a !== 16'd0 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_counts: got tog %0d err %0d/%b required 4 0/0",
               tog_a, ecnt_a, err_a);
    end
    n_chk++;
    if ({in3_a, in2_a, in1_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL nom_idle_vec: got %b required 000",
               {in3_a, in2_a, in1_a});
    end
  endtask

  task automatic test_stuck1();
    int bl, dc, da, vb;
    mode_a = 1;
    pulse_start_a();
    run_a(1'b0, bl, dc, da, vb);
    n_chk++;
    if (ecnt_a !== 16'd6 || tog_a !== 16'd0) begin
      n_fail++;
      $display("FAIL s1_counts: got err %0d tog %0d required 6 0",
               ecnt_a, tog_a);
    end
    n_chk++;
    if (err_a !== 1'b1 || fev_a !== 3'b110) begin
      n_fail++;
      $display("FAIL s1_err: got %b vec %b required 1 110",
               err_a, fev_a);
    end
    n_chk++;
    if (dc !== 1 || bl !== 48) begin
      n_fail++;
      $display("FAIL s1_done: got %0d pulses busy %0d required 1 48",
               dc, bl);
    end
    mode_a = 0;
  endtask

  task automatic test_abort();
    int bl, dc, da, vb;
    int dn;
    mode_a = 0;
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    n_chk++;
    if (busy_a !== 1'b0 || ecnt_a !== 16'd6 || err_a !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_abort: got busy %b err %0d/%b required 0 6/1",
               busy_a, ecnt_a, err_a);
    end
    pulse_start_a();
    repeat (19) tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    n_chk++;
    if (busy_a !== 1'b0 || {in3_a, in2_a, in1_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_stop: got busy %b vec %b required 0 000",
               busy_a, {in3_a, in2_a, in1_a});
    end
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_a) dn++;
      tick();
    end
    n_chk++;
    if (dn !== 0 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d pulses required 0", dn);
    end
    n_chk++;
    if (tog_a !== 16'd1 || ecnt_a !== 16'd0 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_counts: got tog %0d err %0d/%b required 1 0/0",
               tog_a, ecnt_a, err_a);
    end
    pulse_start_a();
    n_chk++;
    if (busy_a !== 1'b1 || tog_a !== 16'd0) begin
      n_fail++;
      $display("FAIL restart_clear: got busy %b tog %0d required 1 0",
               busy_a, tog_a);
    end
    run_a(1'b0, bl, dc, da, vb);
    n_chk++;
    if (bl !== 48 || dc !== 1 || tog_a !== 16'd4 || vb !== 0) begin
      n_fail++;
      $display("FAIL restart_run: got busy %0d done %0d tog %0d bad %0d",
               bl, dc, tog_a, vb);
    end
  endtask

  task automatic test_back_to_back();
    int bl, dc, da, vb;
    mode_a = 0;
    pulse_start_a();
    run_a(1'b1, bl, dc, da, vb);
    n_chk++;
    if (bl !== 48 || da !== 49) begin
      n_fail++;
      $display("FAIL b2b_len: got busy %0d done at %0d required 48 49",
               bl, da);
    end
    n_chk++;
    if (dc !== 1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d pulses busy %b required 1 0",
               dc, busy_a);
    end
  endtask

  task automatic test_dwell1();
    int bl, dc, da, vb;
    mode_b = 0;
    pulse_start_b();
    bl = 0; dc = 0; da = 0; vb = 0;
    for (int i = 1; i <= 12; i++) begin
      if (busy_b) begin
        if ({in3_b, in2_b, in1_b} !== gray(bl)) vb++;
        bl++;
      end
      if (done_b) begin
        dc++;
        if (da == 0) da = i;
      end
      tick();
    end
    n_chk++;
    if (bl !== 8 || vb !== 0) begin
      n_fail++;
      $display("FAIL d1_run: got busy %0d bad %0d required 8 0", bl, vb);
    end
    n_chk++;
    if (dc !== 1 || da !== 9) begin
      n_fail++;
      $display("FAIL d1_done: got %0d at %0d required 1 at 9", dc, da);
    end
    n_chk++;
    if (tog_b !== 2'd2 || ecnt_b !== 2'd0 || err_b !== 1'b0) begin
      n_fail++;
      $display("FAIL d1_counts: got tog %0d err %0d/%b required 2 0/0",
               tog_b, ecnt_b, err_b);
    end
    mode_b = 2;
    pulse_start_b();
    repeat (10) tick();
    n_chk++;
    if (ecnt_b !== 2'd3 || tog_b !== 2'd0 || err_b !== 1'b1) begin
      n_fail++;
      $display("FAIL d1_saturate: got err %0d tog %0d %b required 3 0 1",
               ecnt_b, tog_b, err_b);
    end
    mode_b = 0;
  endtask

  task automatic test_reset_midrun();
    int dn;
    mode_b = 0;
    pulse_start_b();
    repeat (4) tick();
    n_chk++;
    if (busy_b !== 1'b1 || {in3_b, in2_b, in1_b} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_pre: got busy %b vec %b required 1 110",
               busy_b, {in3_b, in2_b, in1_b});
    end
    rstb = 1'b0;
    #1;
    n_chk++;
    if ({in3_b, in2_b, in1_b, busy_b, done_b, err_b,
         tog_b, ecnt_b, fev_b} !== 13'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got %b required 0",
               {in3_b, in2_b, in1_b, busy_b, done_b, err_b,
                tog_b, ecnt_b, fev_b});
    end
    tick();
    rstb = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_b || busy_b) dn++;
      tick();
    end
    n_chk++;
    if (dn !== 0) begin
      n_fail++;
      $display("FAIL mid_after: got %0d busy/done cycles required 0", dn);
    end
  endtask

  initial begin
    rstb = 1'b0;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    mode_a = 0; mode_b = 0;
    test_reset();
    test_nominal();
    test_stuck1();
    test_abort();
    test_back_to_back();
    test_dwell1();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oai21_toggle_sequencer.md
Name: oai21_toggle_sequencer

Overview:
- Stimulus controller for power/functional characterisation of one OAI21 cell instance; QN = ~((IN1 | IN2) & IN3).
- Walks the three cell inputs through a 3-bit Gray sequence (one input switches per step) for a programmable number of passes.
- Samples the cell's QN after a dwell period, checks it against the expected logic value, and counts QN toggles and mismatches.
- Sits between the test-power harness (START/DONE handshake) and the cell under test.

Parameters:
- DWELL_CYCLES, 4, cycles each input vector is held (>=1); QN is sampled on the last cycle of the dwell.
- REPS, 16, number of full 8-vector Gray passes per run (>=1).
- CNT_W, 16, width of TOGGLE_CNT and ERR_CNT.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTB  input  1  reset, asynchronous, active-low.
- START  input  1  run request; sampled only in IDLE.
- ABORT  input  1  synchronous abort; ends the run early.
- QN_OBS  input  1  observed QN of the cell under test.
- IN1  output  1  drive to cell IN1; vector bit0; registered.
- IN2  output  1  drive to cell IN2; vector bit1; registered.
- IN3  output  1  drive to cell IN3; vector bit2; registered.
- BUSY  output  1  high in RUN.
- DONE  output  1  one-cycle pulse on normal completion.
- ERR  output  1  sticky; set on any mismatch.
- TOGGLE_CNT  output  CNT_W  QN_OBS changes between consecutive samples.
- ERR_CNT  output  CNT_W  number of mismatched samples.
- FIRST_ERR_VEC  output  3  {IN3,IN2,IN1} of the first mismatch.

Behaviour:
- Reset (RSTB=0, async): state=IDLE. IN1=IN2=IN3=0, BUSY=0, DONE=0, ERR=0, TOGGLE_CNT=0, ERR_CNT=0, FIRST_ERR_VEC=0. Internal step, dwell and rep counters=0; prev-sample valid=0.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 -> RUN.
  - On the same edge, clear TOGGLE_CNT, ERR_CNT, ERR, FIRST_ERR_VEC and prev-valid; load vector 000; dwell=0, step=0, rep=0.
- RUN:
  - BUSY=1.
  - Gray order {IN3,IN2,IN1}: 000,001,011,010,110,111,101,100, then wrap to 000 for the next rep. Every step, including the wrap, changes exactly one input.
  - dwell increments each cycle.
  - At dwell==DWELL_CYCLES-1 (sample edge):
    - Compare QN_OBS against expected = ~((IN1|IN2)&IN3) of the current vector.
    - Mismatch: ERR_CNT+1; ERR<=1; if this is the first mismatch, capture FIRST_ERR_VEC.
    - If prev-valid and QN_OBS!=prev sample: TOGGLE_CNT+1.
    - Store the sample; prev-valid<=1.
    - Advance to the next vector; dwell<=0.
  - After the sample of step 7 of rep REPS-1 -> FIN; outputs return to 000.
- Expected QN per pass is 1,1,1,1,0,0,0,1: two toggles per pass, none at the wrap. A correct cell gives TOGGLE_CNT = 2*REPS, ERR_CNT = 0.
- Run latency: BUSY high for exactly REPS*8*DWELL_CYCLES cycles. DONE=1 in the following cycle (FIN), then IDLE.
- FIN: DONE=1, BUSY=0; unconditional -> IDLE.
- Counters saturate at all-ones and never wrap.
- Results (counts, ERR, FIRST_ERR_VEC) hold until the next accepted START.
- START while BUSY or in FIN: ignored.
- ABORT in RUN:
  - Next state IDLE; vector <=000; no DONE pulse; counts frozen at their current values.
  - ABORT has priority over a coincident sample edge; that sample is discarded.
  - ABORT in IDLE or FIN: no effect.
- Reset mid-run: immediate return to reset values; no DONE pulse.

Test Plan:
- Reset: hold RSTB=0, toggle START and QN_OBS -> all outputs 0, BUSY=0, no DONE.
- Nominal (REPS=2, DWELL_CYCLES=3, bench QN_OBS = ideal OAI21 of IN1..IN3):
  - START pulse -> BUSY high 48 cycles; IN sequence matches Gray order, each vector held 3 cycles.
  - DONE pulse on cycle 49; TOGGLE_CNT=4, ERR_CNT=0, ERR=0.
- Stuck-at-1 QN_OBS (REPS=2, DWELL_CYCLES=3) -> ERR_CNT=6, TOGGLE_CNT=0, ERR=1, FIRST_ERR_VEC=110, DONE asserted.
- ABORT asserted on BUSY cycle 20 (ideal QN) -> IDLE next cycle, IN=000, no DONE, TOGGLE_CNT=1, ERR_CNT=0; a new START then clears counts and runs to completion.
- START re-asserted during BUSY and on the DONE cycle -> ignored; run length unchanged; exactly one DONE pulse.
- DWELL_CYCLES=1, REPS=1, ideal QN -> BUSY 8 cycles; vector changes every cycle; TOGGLE_CNT=2. Separately, RSTB pulsed low on BUSY cycle 5 -> all outputs return to reset values at once.
